// File: rtl/ic_block_read_scheduler.sv
// Walks a frame in 8x8-block raster order, launching one read-master burst per block row
// and holding back new blocks while the downstream credit window is full.
module ic_block_read_scheduler #(
  parameter int BLK_DIM       = 8,
  parameter int BYTES_PER_PIX = 4,
  parameter int MAX_OUTSTD    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_base,
  input  logic [31:0] cfg_stride,
  input  logic [11:0] cfg_width_blk,
  input  logic [11:0] cfg_height_blk,
  input  logic        MR_readdatavalid,
  input  logic        blk_consumed,
  output logic        MR_start,
  output logic [31:0] MR_address,
  output logic [31:0] MR_length,
  output logic [2:0]  MR_addressinc,
  output logic        busy,
  output logic        done,
  output logic [11:0] blk_x,
  output logic [11:0] blk_y
);

  localparam int              CW        = $clog2(BLK_DIM);
  localparam logic [CW-1:0]   LAST_IDX  = CW'(BLK_DIM - 1);
  localparam logic [CW-1:0]   ONE_IDX   = CW'(1);
  localparam logic [31:0]     BLK_BYTES = 32'(BLK_DIM * BYTES_PER_PIX);
  localparam logic [2:0]      MAX_CRED  = 3'(MAX_OUTSTD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ROW = 3'd3,
    FIN      = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_stride;
  logic [11:0]   r_width_blk;
  logic [11:0]   r_height_blk;
  logic [31:0]   r_line_addr;
  logic [31:0]   r_blk_addr;
  logic [31:0]   r_row_addr;
  logic [11:0]   r_blk_x;
  logic [11:0]   r_blk_y;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_beat_cnt;
  logic [2:0]    r_outstd;
  logic          r_mr_start;
  logic          r_busy;
  logic          r_done;

  logic          w_last_beat;
  logic          w_last_row;
  logic          w_blk_done;
  logic          w_last_col;
  logic          w_last_blk;
  logic          w_cfg_empty;
  logic [31:0]   w_next_blk_addr;
  logic [31:0]   w_next_line_addr;

  assign w_last_beat      = (r_state == WAIT_ROW) && MR_readdatavalid && (r_beat_cnt == LAST_IDX);
  assign w_last_row       = (r_row == LAST_IDX);
  assign w_blk_done       = w_last_beat && w_last_row;
  assign w_last_col       = (r_blk_x == (r_width_blk - 12'd1));
  assign w_last_blk       = w_last_col && (r_blk_y == (r_height_blk - 12'd1));
  assign w_cfg_empty      = (cfg_width_blk == 12'd0) || (cfg_height_blk == 12'd0);
  assign w_next_blk_addr  = r_blk_addr + BLK_BYTES;
  // One block-row down is BLK_DIM lines; BLK_DIM is a power of two so this is a shift.
  assign w_next_line_addr = r_line_addr + (r_stride << CW);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the block walk.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_state_nxt = w_cfg_empty ? FIN : CHECK;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (r_outstd >= MAX_CRED) begin
          w_state_nxt = CHECK;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT_ROW;
      WAIT_ROW: begin
        if (!w_last_beat) begin
          w_state_nxt = WAIT_ROW;
        end else if (!w_last_row) begin
          w_state_nxt = ISSUE;
        end else if (w_last_blk) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = CHECK;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Config latch, address accumulators, beat/row counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stride     <= 32'd0;
      r_width_blk  <= 12'd0;
      r_height_blk <= 12'd0;
      r_line_addr  <= 32'd0;
      r_blk_addr   <= 32'd0;
      r_row_addr   <= 32'd0;
      r_blk_x      <= 12'd0;
      r_blk_y      <= 12'd0;
      r_row        <= '0;
      r_beat_cnt   <= '0;
      r_mr_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mr_start <= (w_state_nxt == ISSUE);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == FIN);
      if ((r_state == IDLE) && cfg_start) begin
        r_stride     <= cfg_stride;
        r_width_blk  <= cfg_width_blk;
        r_height_blk <= cfg_height_blk;
        r_line_addr  <= cfg_base;
        r_blk_addr   <= cfg_base;
        r_row_addr   <= cfg_base;
        r_blk_x      <= 12'd0;
        r_blk_y      <= 12'd0;
        r_row        <= '0;
        r_beat_cnt   <= '0;
      end else if (r_state == ISSUE) begin
        r_beat_cnt <= '0;
      end else if ((r_state == WAIT_ROW) && MR_readdatavalid) begin
        r_beat_cnt <= r_beat_cnt + ONE_IDX;
        if (w_last_beat && !w_last_row) begin
          r_row      <= r_row + ONE_IDX;
          r_row_addr <= r_row_addr + r_stride;
        end else if (w_blk_done && !w_last_blk) begin
          r_row <= '0;
          if (!w_last_col) begin
            r_blk_x    <= r_blk_x + 12'd1;
            r_blk_addr <= w_next_blk_addr;
            r_row_addr <= w_next_blk_addr;
          end else begin
            r_blk_x     <= 12'd0;
            r_blk_y     <= r_blk_y + 12'd1;
            r_line_addr <= w_next_line_addr;
            r_blk_addr  <= w_next_line_addr;
            r_row_addr  <= w_next_line_addr;
          end
        end
      end
    end
  end

  // Credit window: completed-but-unconsumed blocks, never below zero, kept across frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_outstd <= 3'd0;
    end else if (w_blk_done && !blk_consumed) begin
      r_outstd <= r_outstd + 3'd1;
    end else if (!w_blk_done && blk_consumed && (r_outstd != 3'd0)) begin
      r_outstd <= r_outstd - 3'd1;
    end else begin
      r_outstd <= r_outstd;
    end
  end

  assign MR_start      = r_mr_start;
  assign MR_address    = r_row_addr;
  assign MR_length     = BLK_BYTES;
  assign MR_addressinc = 3'(BYTES_PER_PIX);
  assign busy          = r_busy;
  assign done          = r_done;
  assign blk_x         = r_blk_x;
  assign blk_y         = r_blk_y;

endmodule

// File: tb/tb_ic_block_read_scheduler.sv
// Scoreboard bench for ic_block_read_scheduler: expected bursts are queued as frames are
// launched, and a monitor checks every MR_start against the queue.
module tb_ic_block_read_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic [31:0] cfg_stride;
  logic [11:0] cfg_width_blk;
  logic [11:0] cfg_height_blk;
  logic        MR_readdatavalid;
  logic        blk_consumed;
  logic        MR_start;
  logic [31:0] MR_address;
  logic [31:0] MR_length;
  logic [2:0]  MR_addressinc;
  logic        busy;
  logic        done;
  logic [11:0] blk_x;
  logic [11:0] blk_y;

  typedef struct {
    logic [31:0] addr;
    logic [11:0] bx;
    logic [11:0] by;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;
  int   last_start_cyc = -100;
  int   last_done_cyc = -100;
  int   last_beat_cyc = -100;
  int   beats_left = 0;

  ic_block_read_scheduler dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_start        (cfg_start),
    .cfg_base         (cfg_base),
    .cfg_stride       (cfg_stride),
    .cfg_width_blk    (cfg_width_blk),
    .cfg_height_blk   (cfg_height_blk),
    .MR_readdatavalid (MR_readdatavalid),
    .blk_consumed     (blk_consumed),
    .MR_start         (MR_start),
    .MR_address       (MR_address),
    .MR_length        (MR_length),
    .MR_addressinc    (MR_addressinc),
    .busy             (busy),
    .done             (done),
    .blk_x            (blk_x),
    .blk_y            (blk_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Read master model: 8 beats on consecutive cycles, starting the cycle after MR_start.
  initial begin
    MR_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        beats_left = 0;
        MR_readdatavalid = 1'b0;
      end else begin
        if (beats_left > 0) begin
          MR_readdatavalid = 1'b1;
          beats_left--;
          last_beat_cyc = cyc;
        end else begin
          MR_readdatavalid = 1'b0;
        end
        if (MR_start === 1'b1) beats_left = 8;
      end
    end
  end

  // Monitor: every burst launch must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (MR_start === 1'b1) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("start_addr", MR_address, e.addr);
          check("start_blk_x", 32'(blk_x), 32'(e.bx));
          check("start_blk_y", 32'(blk_y), 32'(e.by));
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic push_frame(input logic [31:0] base, input logic [31:0] stride,
                            input int w, input int first, input int nblk);
    exp_t e;
    int   bx;
    int   by;
    for (int k = first; k < first + nblk; k++) begin
      bx = k % w;
      by = k / w;
      for (int r = 0; r < 8; r++) begin
        e.addr = base + 32'(by * 8 + r) * stride + 32'(bx * 32);
        e.bx   = 12'(bx);
        e.by   = 12'(by);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                             input int w, input int h, output int t0);
    @(negedge clk);
    cfg_base       = base;
    cfg_stride     = stride;
    cfg_width_blk  = 12'(w);
    cfg_height_blk = 12'(h);
    cfg_start      = 1'b1;
    t0             = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n = 0;
    while ((start_cnt < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(start_cnt), 32'(target));
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int n = 0;
    while ((done_cnt <= d0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic pulse_consumed(output int c);
    @(negedge clk);
    blk_consumed = 1'b1;
    c = cyc;
    @(negedge clk);
    blk_consumed = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int c;
    int s0;
    int d0;
    int n;
    reset_n        = 1'b0;
    cfg_start      = 1'b0;
    cfg_base       = 32'd0;
    cfg_stride     = 32'd0;
    cfg_width_blk  = 12'd0;
    cfg_height_blk = 12'd0;
    blk_consumed   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mr_start", 32'(MR_start), 32'd0);
    check("rst_address", MR_address, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_blk_x", 32'(blk_x), 32'd0);
    check("mr_length", MR_length, 32'd32);
    check("mr_addressinc", 32'(MR_addressinc), 32'd4);
    reset_n = 1'b1;

    // 1) 2x1 blocks, consumer always ready.
    blk_consumed = 1'b1;
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'h0000_1000, 32'd64, 2, 0, 2);
    start_frame(32'h0000_1000, 32'd64, 2, 1, t0);
    wait_starts("t1_first_start", s0 + 1, 10);
    check("t1_latency", 32'(last_start_cyc), 32'(t0 + 2));
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", d0, 300);
    check("t1_start_count", 32'(start_cnt - s0), 32'd16);
    check("t1_done_after_beat", 32'(last_done_cyc), 32'(last_beat_cyc + 1));
    @(negedge clk);
    check("t1_busy_clear", 32'(busy), 32'd0);
    blk_consumed = 1'b0;

    // 2) 3x1 blocks, no consumption: two blocks then hold; mid-frame cfg_start ignored.
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'h0000_2000, 32'd128, 3, 0, 2);
    start_frame(32'h0000_2000, 32'd128, 3, 1, t0);
    wait_starts("t2_two_blocks", s0 + 16, 300);
    repeat (40) @(negedge clk);
    check("t2_stall_count", 32'(start_cnt - s0), 32'd16);
    check("t2_stall_busy", 32'(busy), 32'd1);
    check("t2_stall_blk_x", 32'(blk_x), 32'd2);
    start_frame(32'h0000_9000, 32'd4, 5, 5, t0);
    push_frame(32'h0000_2000, 32'd128, 3, 2, 1);
    pulse_consumed(c);
    wait_starts("t2_third_block", s0 + 17, 20);
    check("t2_resume_latency", 32'(last_start_cyc), 32'(c + 2));
    wait_done("t2_done", d0, 200);
    check("t2_start_count", 32'(start_cnt - s0), 32'd24);

    // 3) credits: 2 -> 1, then completion coinciding with consumption keeps 1.
    pulse_consumed(c);
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'h0000_4000, 32'd64, 1, 0, 1);
    start_frame(32'h0000_4000, 32'd64, 1, 1, t0);
    wait_starts("t3a_rows", s0 + 8, 200);
    n = 0;
    while ((cyc < last_start_cyc + 8) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    blk_consumed = 1'b1;
    @(negedge clk);
    blk_consumed = 1'b0;
    wait_done("t3a_done", d0, 50);
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'h0000_4400, 32'd64, 2, 0, 1);
    start_frame(32'h0000_4400, 32'd64, 2, 1, t0);
    wait_starts("t3b_one_block", s0 + 8, 200);
    repeat (40) @(negedge clk);
    check("t3b_stall_count", 32'(start_cnt - s0), 32'd8);
    check("t3b_stall_busy", 32'(busy), 32'd1);
    push_frame(32'h0000_4400, 32'd64, 2, 1, 1);
    pulse_consumed(c);
    wait_done("t3b_done", d0, 200);
    for (int i = 0; i < 4; i++) pulse_consumed(c);
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'h0000_6000, 32'd32, 3, 0, 2);
    start_frame(32'h0000_6000, 32'd32, 3, 1, t0);
    wait_starts("t3c_after_underflow", s0 + 16, 300);
    repeat (40) @(negedge clk);
    check("t3c_stall_count", 32'(start_cnt - s0), 32'd16);
    push_frame(32'h0000_6000, 32'd32, 3, 2, 1);
    blk_consumed = 1'b1;
    wait_done("t3c_done", d0, 200);

    // 4) empty frames: done one cycle after cfg_start, no bursts.
    for (int k = 0; k < 2; k++) begin
      s0 = start_cnt;
      d0 = done_cnt;
      start_frame(32'h0000_7000, 32'd64, (k == 0) ? 0 : 2, (k == 0) ? 1 : 0, t0);
      repeat (3) @(negedge clk);
      check("t4_done_count", 32'(done_cnt), 32'(d0 + 1));
      check("t4_done_latency", 32'(last_done_cyc), 32'(t0 + 1));
      check("t4_no_start", 32'(start_cnt - s0), 32'd0);
    end

    // 5) reset in the middle of block (1,0), then a fresh frame.
    s0 = start_cnt;
    push_frame(32'h0000_3000, 32'd64, 2, 0, 1);
    push_frame(32'h0000_3000, 32'd64, 2, 1, 1);
    while (exp_q.size() > 9) exp_q.pop_back();
    start_frame(32'h0000_3000, 32'd64, 2, 1, t0);
    wait_starts("t5_into_block1", s0 + 9, 200);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_mr_start", 32'(MR_start), 32'd0);
    check("t5_rst_address", MR_address, 32'd0);
    check("t5_rst_blk_x", 32'(blk_x), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_start_after_rst", 32'(start_cnt - s0), 32'd9);
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'h0000_5000, 32'd16, 1, 0, 1);
    start_frame(32'h0000_5000, 32'd16, 1, 1, t0);
    wait_starts("t5_restart", s0 + 1, 10);
    check("t5_restart_latency", 32'(last_start_cyc), 32'(t0 + 2));
    wait_done("t5_done", d0, 200);

    // 6) 32-bit address wrap over a 2x2 frame.
    s0 = start_cnt;
    d0 = done_cnt;
    push_frame(32'hFFFF_FFE0, 32'd32, 2, 0, 4);
    start_frame(32'hFFFF_FFE0, 32'd32, 2, 2, t0);
    wait_done("t6_done", d0, 600);
    check("t6_start_count", 32'(start_cnt - s0), 32'd32);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
